// File: rtl/vga_pkg.sv
// Shared types and helpers for the multi-buffered VGA frame store.
// Clear FSM state type is used only when VGA_MULTIBUF_CLEAR_EN is defined.
package vga_pkg;

    localparam int VGA_MAX_BUFFERS = 4;
    localparam int VGA_COLOR_W     = 12;

    typedef logic [VGA_COLOR_W-1:0] vga_color_t;
    typedef logic [1:0]             vga_buf_idx_t;

    localparam vga_color_t VGA_BLANK = '0;

    typedef enum logic {
        CLR_IDLE,
        CLR_CLEAR
    } vga_clr_state_t;

    // Lowest buffer index that is neither displayed nor queued for display.
    function automatic vga_buf_idx_t next_free_idx(
        input vga_buf_idx_t front,
        input vga_buf_idx_t pend,
        input int           n
    );
        vga_buf_idx_t r;
        r = '0;
        for (int i = VGA_MAX_BUFFERS - 1; i >= 0; i--) begin
            if (i < n && vga_buf_idx_t'(i) != front &&
                vga_buf_idx_t'(i) != pend)
                r = vga_buf_idx_t'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_frame_ram.sv
// One frame of pixel storage: write port on the CPU clock,
// registered read port on the pixel clock.
module vga_frame_ram
    import vga_pkg::*;
#(
    parameter int NPIX    = 19200,
    parameter int ADDR_W  = 15,
    parameter int COLOR_W = 12
) (
    input  logic               i_wr_clk,
    input  logic               i_wr_en,
    input  logic [ADDR_W-1:0]  i_wr_addr,
    input  logic [COLOR_W-1:0] i_wr_data,
    input  logic               i_rd_clk,
    input  logic [ADDR_W-1:0]  i_rd_addr,
    output logic [COLOR_W-1:0] o_rd_data
);

    logic [COLOR_W-1:0] r_mem [NPIX];
    logic [COLOR_W-1:0] r_q;

    always_ff @(posedge i_wr_clk) begin
        if (i_wr_en)
            r_mem[i_wr_addr] <= i_wr_data;
    end

    always_ff @(posedge i_rd_clk) begin
        r_q <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_q;

endmodule

// File: rtl/vga_multibuf.sv
// N-way VGA frame buffer; swaps commit only at frame start.
// Define VGA_MULTIBUF_CLEAR_EN to zero each new back buffer after a swap.
module vga_multibuf
    import vga_pkg::*;
#(
    parameter int NUM_BUFFERS = 2,
    parameter int H_RES       = 160,
    parameter int V_RES       = 120,
    parameter int COLOR_W     = 12,
    localparam int NPIX   = H_RES * V_RES,
    localparam int ADDR_W = $clog2(NPIX),
    localparam int IDX_W  = (NUM_BUFFERS > 2) ? $clog2(NUM_BUFFERS) : 1,
    localparam int X_W    = $clog2(H_RES),
    localparam int Y_W    = $clog2(V_RES)
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_vga_clk,
    input  logic               i_wr_en,
    input  logic [ADDR_W-1:0]  i_wr_addr,
    input  logic [COLOR_W-1:0] i_wr_data,
    input  logic               i_swap_req,
    output logic               o_busy,
    output logic               o_swap_pending,
    output logic               o_swap_overrun,
    output logic [IDX_W-1:0]   o_front_idx,
    input  logic               i_vga_frame_start,
    input  logic [X_W-1:0]     i_pxlX,
    input  logic [Y_W-1:0]     i_pxlY,
    output logic [COLOR_W-1:0] o_color
);

    logic [1:0] r_rst_c;
    logic [1:0] r_rst_v;
    logic       w_rst_c_n;
    logic       w_rst_v_n;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_rst_c <= '0;
        else            r_rst_c <= {r_rst_c[0], 1'b1};
    end

    always_ff @(posedge i_vga_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_rst_v <= '0;
        else            r_rst_v <= {r_rst_v[0], 1'b1};
    end

    assign w_rst_c_n = r_rst_c[1];
    assign w_rst_v_n = r_rst_v[1];

    // Frame start crosses as a toggle, then edge-detected on i_clk.
    logic       r_fs_tog;
    logic [2:0] r_fs_sync;
    logic       w_fs_clk;

    always_ff @(posedge i_vga_clk or negedge w_rst_v_n) begin
        if (!w_rst_v_n)             r_fs_tog <= 1'b0;
        else if (i_vga_frame_start) r_fs_tog <= ~r_fs_tog;
    end

    always_ff @(posedge i_clk or negedge w_rst_c_n) begin
        if (!w_rst_c_n) r_fs_sync <= '0;
        else            r_fs_sync <= {r_fs_sync[1:0], r_fs_tog};
    end

    assign w_fs_clk = r_fs_sync[2] ^ r_fs_sync[1];

    logic [IDX_W-1:0] r_front;
    logic [IDX_W-1:0] r_back;
    logic [IDX_W-1:0] r_pend;
    logic [IDX_W-1:0] w_next_back;
    logic             r_pending;
    logic             r_overrun;
    logic             w_busy;
    logic             w_clearing;
    logic             w_accept;
    logic             w_reject;
    logic             w_commit;

    assign w_busy   = (NUM_BUFFERS == 2 && r_pending) || w_clearing;
    assign w_accept = i_swap_req && !r_pending && !w_busy;
    assign w_reject = i_swap_req && !w_accept;
    assign w_commit = w_fs_clk && r_pending;

    if (NUM_BUFFERS == 2) begin : g_nb2
        assign w_next_back = r_back;
    end else begin : g_nbn
        assign w_next_back = IDX_W'(next_free_idx(
            vga_buf_idx_t'(r_front), vga_buf_idx_t'(r_back), NUM_BUFFERS));
    end

    always_ff @(posedge i_clk or negedge w_rst_c_n) begin
        if (!w_rst_c_n) begin
            r_front   <= '0;
            r_back    <= IDX_W'(1);
            r_pend    <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pend    <= r_back;
                r_back    <= w_next_back;
                r_pending <= 1'b1;
                r_overrun <= 1'b0;
            end else if (w_commit) begin
                r_front   <= r_pend;
                r_pending <= 1'b0;
                if (NUM_BUFFERS == 2)
                    r_back <= r_front;
            end
            if (w_reject)
                r_overrun <= 1'b1;
        end
    end

    logic [ADDR_W-1:0] w_clr_addr;
    logic [IDX_W-1:0]  w_clr_idx;

`ifdef VGA_MULTIBUF_CLEAR_EN
    vga_clr_state_t    r_clr_state;
    vga_clr_state_t    w_clr_next;
    logic [ADDR_W-1:0] r_clr_addr;
    logic [IDX_W-1:0]  r_clr_idx;
    logic              w_clr_start;
    logic              w_clr_last;

    // With two buffers the new back buffer only exists once the swap commits.
    assign w_clr_start = (NUM_BUFFERS == 2) ? w_commit : w_accept;
    assign w_clr_last  = r_clr_addr == ADDR_W'(NPIX - 1);

    always_ff @(posedge i_clk or negedge w_rst_c_n) begin
        if (!w_rst_c_n) r_clr_state <= CLR_IDLE;
        else            r_clr_state <= w_clr_next;
    end

    always_comb begin
        w_clr_next = r_clr_state;
        unique case (r_clr_state)
            CLR_IDLE:  if (w_clr_start) w_clr_next = CLR_CLEAR;
            CLR_CLEAR: if (w_clr_last)  w_clr_next = CLR_IDLE;
            default:   w_clr_next = CLR_IDLE;
        endcase
    end

    always_comb begin
        w_clearing = (r_clr_state == CLR_CLEAR);
    end

    always_ff @(posedge i_clk or negedge w_rst_c_n) begin
        if (!w_rst_c_n) begin
            r_clr_addr <= '0;
            r_clr_idx  <= '0;
        end else if (w_clr_start) begin
            r_clr_addr <= '0;
            r_clr_idx  <= (NUM_BUFFERS == 2) ? r_front : w_next_back;
        end else if (w_clearing) begin
            r_clr_addr <= r_clr_addr + ADDR_W'(1);
        end
    end

    assign w_clr_addr = r_clr_addr;
    assign w_clr_idx  = r_clr_idx;
`else
    assign w_clearing = 1'b0;
    assign w_clr_addr = '0;
    assign w_clr_idx  = '0;
`endif

    logic               w_addr_ok;
    logic               w_ram_we;
    logic [ADDR_W-1:0]  w_ram_addr;
    logic [COLOR_W-1:0] w_ram_data;
    logic [IDX_W-1:0]   w_ram_sel;

    assign w_addr_ok = {1'b0, i_wr_addr} < (ADDR_W + 1)'(NPIX);

    always_comb begin
        w_ram_we   = i_wr_en && !w_busy && w_addr_ok;
        w_ram_addr = i_wr_addr;
        w_ram_data = i_wr_data;
        w_ram_sel  = r_back;
        if (w_clearing) begin
            w_ram_we   = 1'b1;
            w_ram_addr = w_clr_addr;
            w_ram_data = '0;
            w_ram_sel  = w_clr_idx;
        end
    end

    logic               w_oob;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic [COLOR_W-1:0] w_q [NUM_BUFFERS];

    assign w_oob = ({1'b0, i_pxlX} >= (X_W + 1)'(H_RES)) ||
                   ({1'b0, i_pxlY} >= (Y_W + 1)'(V_RES));
    assign w_rd_addr = w_oob ? '0 :
        ADDR_W'(i_pxlY) * ADDR_W'(H_RES) + ADDR_W'(i_pxlX);

    for (genvar g = 0; g < NUM_BUFFERS; g++) begin : g_buf
        vga_frame_ram #(
            .NPIX    (NPIX),
            .ADDR_W  (ADDR_W),
            .COLOR_W (COLOR_W)
        ) u_ram (
            .i_wr_clk  (i_clk),
            .i_wr_en   (w_ram_we && (w_ram_sel == IDX_W'(g))),
            .i_wr_addr (w_ram_addr),
            .i_wr_data (w_ram_data),
            .i_rd_clk  (i_vga_clk),
            .i_rd_addr (w_rd_addr),
            .o_rd_data (w_q[g])
        );
    end

    // Front only changes in vblank, so a plain 2-flop sync is sufficient.
    logic [IDX_W-1:0] r_front_v0;
    logic [IDX_W-1:0] r_front_v1;
    logic             r_oob;

    always_ff @(posedge i_vga_clk or negedge w_rst_v_n) begin
        if (!w_rst_v_n) begin
            r_front_v0 <= '0;
            r_front_v1 <= '0;
            r_oob      <= 1'b1;
        end else begin
            r_front_v0 <= r_front;
            r_front_v1 <= r_front_v0;
            r_oob      <= w_oob;
        end
    end

    assign o_color        = r_oob ? COLOR_W'(VGA_BLANK) : w_q[r_front_v1];
    assign o_busy         = w_busy;
    assign o_swap_pending = r_pending;
    assign o_swap_overrun = r_overrun;
    assign o_front_idx    = r_front;

endmodule

// File: tb/tb_vga_multibuf.sv
// Scoreboard bench: a two-buffer and a three-buffer instance on a 6x5 frame.
`timescale 1ns/1ps
module tb_vga_multibuf;

    localparam int H    = 6;
    localparam int V    = 5;
    localparam int NPIX = H * V;
`ifdef VGA_MULTIBUF_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic clk = 1'b0;
    logic vclk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;
    always #7 vclk = ~vclk;

    logic        wr_en   [2];
    logic [4:0]  wr_addr [2];
    logic [11:0] wr_data [2];
    logic        swap    [2];
    logic        fs      [2];
    logic [2:0]  px      [2];
    logic [2:0]  py      [2];
    logic        busy    [2];
    logic        pend    [2];
    logic        ovr     [2];
    logic [11:0] col     [2];
    logic        f0;
    logic [1:0]  f1;

    vga_multibuf #(.NUM_BUFFERS(2), .H_RES(H), .V_RES(V), .COLOR_W(12)) u2 (
        .i_clk(clk), .i_reset_n(rst_n), .i_vga_clk(vclk),
        .i_wr_en(wr_en[0]), .i_wr_addr(wr_addr[0]), .i_wr_data(wr_data[0]),
        .i_swap_req(swap[0]), .o_busy(busy[0]), .o_swap_pending(pend[0]),
        .o_swap_overrun(ovr[0]), .o_front_idx(f0),
        .i_vga_frame_start(fs[0]), .i_pxlX(px[0]), .i_pxlY(py[0]),
        .o_color(col[0])
    );

    vga_multibuf #(.NUM_BUFFERS(3), .H_RES(H), .V_RES(V), .COLOR_W(12)) u3 (
        .i_clk(clk), .i_reset_n(rst_n), .i_vga_clk(vclk),
        .i_wr_en(wr_en[1]), .i_wr_addr(wr_addr[1]), .i_wr_data(wr_data[1]),
        .i_swap_req(swap[1]), .o_busy(busy[1]), .o_swap_pending(pend[1]),
        .o_swap_overrun(ovr[1]), .o_front_idx(f1),
        .i_vga_frame_start(fs[1]), .i_pxlX(px[1]), .i_pxlY(py[1]),
        .o_color(col[1])
    );

    typedef struct {
        int          d;
        int          kind;
        logic [11:0] exp;
        string       name;
    } exp_t;

    exp_t sq[$];
    exp_t cq[$];
    int   checks = 0;
    int   errors = 0;
    logic rdv   [2];
    logic rdv_d [2];

    function automatic logic [11:0] sample(int d, int kind);
        case (kind)
            0:       return (d == 0) ? {11'b0, f0} : {10'b0, f1};
            1:       return {11'b0, pend[d]};
            2:       return {11'b0, busy[d]};
            3:       return {11'b0, ovr[d]};
            default: return col[d];
        endcase
    endfunction

    task automatic compare(exp_t e, logic [11:0] act);
        checks++;
        if (act !== e.exp) begin
            errors++;
            $display("FAIL %s dut%0d got %h want %h",
                     e.name, e.d, act, e.exp);
        end
    endtask

    always @(negedge clk) begin
        while (sq.size() > 0) begin
            exp_t e;
            e = sq.pop_front();
            compare(e, sample(e.d, e.kind));
        end
    end

    always @(posedge vclk) begin
        rdv_d[0] <= rdv[0];
        rdv_d[1] <= rdv[1];
    end

    always @(negedge vclk) begin
        for (int d = 0; d < 2; d++) begin
            if (rdv_d[d]) begin
                if (cq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL color_queue_empty dut%0d got %h", d, col[d]);
                end else begin
                    exp_t e;
                    e = cq.pop_front();
                    compare(e, col[d]);
                end
            end
        end
    end

    task automatic cyc(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic st(int d, int kind, logic [11:0] v, string nm);
        sq.push_back('{d, kind, v, nm});
    endtask

    task automatic wr(int d, logic [4:0] a, logic [11:0] v);
        cyc();
        wr_en[d] = 1'b1;
        wr_addr[d] = a;
        wr_data[d] = v;
        cyc();
        wr_en[d] = 1'b0;
    endtask

    task automatic swap_p(int d);
        cyc();
        swap[d] = 1'b1;
        cyc();
        swap[d] = 1'b0;
    endtask

    task automatic frame(int d);
        @(posedge vclk);
        #1 fs[d] = 1'b1;
        @(posedge vclk);
        #1 fs[d] = 1'b0;
        cyc(4);
        repeat (3) @(posedge vclk);
        cyc();
    endtask

    task automatic scan(int d, logic [2:0] x, logic [2:0] y,
                        logic [11:0] v, string nm);
        @(posedge vclk);
        #1;
        px[d] = x;
        py[d] = y;
        rdv[d] = 1'b1;
        cq.push_back('{d, 4, v, nm});
        @(posedge vclk);
        #1 rdv[d] = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            wr_en[d] = 1'b0; wr_addr[d] = '0; wr_data[d] = '0;
            swap[d] = 1'b0; fs[d] = 1'b0; px[d] = '0; py[d] = '0;
            rdv[d] = 1'b0; rdv_d[d] = 1'b0;
        end
        cyc(3);
        st(0, 0, 12'h0, "rst_front");
        st(0, 1, 12'h0, "rst_pending");
        st(0, 2, 12'h0, "rst_busy");
        st(0, 3, 12'h0, "rst_overrun");
        st(0, 4, 12'h0, "rst_color");
        st(1, 0, 12'h0, "rst_front3");
        st(1, 4, 12'h0, "rst_color3");
        cyc();
        rst_n = 1'b1;
        cyc(5);
        repeat (5) @(posedge vclk);

        wr(0, 5'd5, 12'hABC);
        wr(0, 5'd7, 12'h555);
        swap_p(0);
        st(0, 1, 12'h1, "n2_pending");
        st(0, 2, 12'h1, "n2_busy_pending");
        st(0, 0, 12'h0, "n2_front_before");
        st(0, 3, 12'h0, "n2_overrun0");
        wr(0, 5'd7, 12'h123);
        swap_p(0);
        st(0, 3, 12'h1, "n2_overrun_set");
        st(0, 1, 12'h1, "n2_still_pending");
        frame(0);
        st(0, 1, 12'h0, "n2_commit_pending");
        st(0, 0, 12'h1, "n2_commit_front");
        st(0, 2, {11'b0, CLR}, "n2_busy_after");
        st(0, 3, 12'h1, "n2_overrun_sticky");
        scan(0, 3'd5, 3'd0, 12'hABC, "n2_pix5");
        scan(0, 3'd1, 3'd1, 12'h555, "n2_write_dropped");
        scan(0, 3'd6, 3'd0, 12'h000, "x_oob");
        scan(0, 3'd0, 3'd5, 12'h000, "y_oob");
        cyc(NPIX + 4);
        wr(0, 5'd0, 12'h0AA);
        wr(0, 5'd30, 12'hFFF);
        swap_p(0);
        st(0, 3, 12'h0, "n2_overrun_cleared");
        st(0, 1, 12'h1, "n2_pending2");
        frame(0);
        st(0, 0, 12'h0, "n2_front_back0");
        scan(0, 3'd0, 3'd0, 12'h0AA, "n2_addr_oob_write");

        wr(1, 5'd3, 12'h222);
        swap_p(1);
        st(1, 1, 12'h1, "n3_pending");
        st(1, 2, {11'b0, CLR}, "n3_busy");
`ifdef VGA_MULTIBUF_CLEAR_EN
        cyc(NPIX - 1);
        st(1, 2, 12'h1, "clr_busy_last");
        cyc();
        st(1, 2, 12'h0, "clr_busy_done");
`endif
        wr(1, 5'd3, 12'h111);
        frame(1);
        st(1, 0, 12'h1, "n3_front1");
        st(1, 1, 12'h0, "n3_commit_pending");
        scan(1, 3'd3, 3'd0, 12'h222, "n3_show_buf1");
        swap_p(1);
        frame(1);
        st(1, 0, 12'h2, "n3_front2");
        scan(1, 3'd3, 3'd0, 12'h111, "n3_show_buf2");
`ifdef VGA_MULTIBUF_CLEAR_EN
        cyc(NPIX + 4);
        swap_p(1);
        frame(1);
        st(1, 0, 12'h0, "clr_front0");
        scan(1, 3'd0, 3'd0, 12'h000, "clr_pix0");
        scan(1, 3'd3, 3'd2, 12'h000, "clr_pix15");
        scan(1, 3'd5, 3'd4, 12'h000, "clr_pixlast");
`endif

        cyc(NPIX + 4);
        swap_p(0);
        swap_p(0);
        st(0, 1, 12'h1, "rst_test_pending");
        st(0, 3, 12'h1, "rst_test_overrun");
        cyc();
        rst_n = 1'b0;
        cyc();
        st(0, 0, 12'h0, "midrst_front");
        st(0, 1, 12'h0, "midrst_pending");
        st(0, 3, 12'h0, "midrst_overrun");
        st(0, 2, 12'h0, "midrst_busy");
        st(1, 0, 12'h0, "midrst_front3");
        cyc();
        rst_n = 1'b1;
        cyc(5);
        repeat (5) @(posedge vclk);
        frame(0);
        st(0, 1, 12'h0, "post_rst_no_pending");
        st(0, 0, 12'h0, "post_rst_no_commit");

        cyc(3);
        repeat (3) @(posedge vclk);
        cyc(2);
        if (sq.size() != 0 || cq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL queues_not_drained got %0d want 0",
                     sq.size() + cq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
